// File: rtl/inst_fetch_pkg.sv
// Shared types and helpers for the LoongArch-32 instruction fetch stage.
package inst_fetch_pkg;

  localparam int unsigned WORD = 32;

  typedef logic [WORD-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'h1C00_0000;

  typedef struct packed {
    word_t pc;
    word_t inst;
  } fq_entry_t;

  function automatic word_t word_align(word_t a);
    return a & ~word_t'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Registered {pc, inst} fetch queue with push, pop, flush and occupancy count.
module inst_fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [31:0]                  push_pc_i,
  input  logic [31:0]                  push_inst_i,
  input  logic                         pop_i,
  output logic [31:0]                  head_pc_o,
  output logic [31:0]                  head_inst_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  fq_entry_t        mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage is cleared on reset so the head reads as zero before first use.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= '{pc: push_pc_i, inst: push_inst_i};
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_pc_o   = mem_q[rd_ptr_q].pc;
  assign head_inst_o = mem_q[rd_ptr_q].inst;
  assign count_o     = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, issues in-order word requests, buffers responses
// for decode and discards stale in-flight responses after a redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int unsigned CW = $clog2(FQ_DEPTH + 1);
  localparam word_t       PC_RST = word_align(RESET_PC);

  word_t          pc_q, pc_d;
  word_t          resp_pc_q, resp_pc_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  discard_q, discard_d;
  logic [CW-1:0]  count;
  logic [CW:0]    occupancy;
  word_t          target_pc;
  logic           grant;
  logic           push;
  logic           pop;

  assign target_pc = word_align(redirect_pc);
  assign occupancy = {1'b0, inflight_q} + {1'b0, count};

  // Request depends only on registered counts, redirect and reset.
  assign imem_req  = rstn & ~redirect_valid & (occupancy < (CW+1)'(FQ_DEPTH));
  assign imem_addr = pc_q;
  assign grant     = imem_req & imem_gnt;

  assign push     = imem_rvalid & ~redirect_valid & (discard_q == '0);
  assign id_valid = (count != '0) & ~redirect_valid;
  assign pop      = id_valid & id_ready;

  always_comb begin
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(grant) - CW'(imem_rvalid);
    if (redirect_valid) begin
      pc_d      = target_pc;
      resp_pc_d = target_pc;
      // Already-discarded responses are a subset of inflight, so every
      // outstanding response becomes stale exactly once.
      discard_d = inflight_q - CW'(imem_rvalid);
    end else begin
      if (grant) begin
        pc_d = pc_q + 32'd4;
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
      end
      if (imem_rvalid && (discard_q != '0)) begin
        discard_d = discard_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= PC_RST;
      resp_pc_q  <= PC_RST;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  inst_fetch_fifo #(
    .DEPTH (FQ_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_pc_i   (resp_pc_q),
    .push_inst_i (imem_rdata),
    .pop_i       (pop),
    .head_pc_o   (id_pc),
    .head_inst_o (id_inst),
    .count_o     (count)
  );

endmodule
